// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer for one shared request/response port.
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [dataWidth-1:0] din0,
  input  logic [dataWidth-1:0] din1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic                 sel,
  output logic                 bus_valid,
  output logic [dataWidth-1:0] bus_data,
  input  logic                 bus_ready,
  input  logic                 bus_resp_valid,
  input  logic [dataWidth-1:0] bus_rdata,
  output logic [dataWidth-1:0] rdata
);

  // state    | meaning
  // ST_IDLE  | no transaction in flight; req0/req1 sampled here
  // ST_ISSUE | winner's payload presented, bus_valid high until bus_ready
  // ST_WAIT  | request accepted, waiting for bus_resp_valid
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state;
  logic   last;
  logic   winner;

  // Winner is only consumed when a request is present; with none it defaults to the previous owner.
  always_comb begin
    winner = last;
`ifdef ARB_ROUND_ROBIN_EN
    case ({req1, req0})
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = last;
    endcase
`else
    if (req0) begin
      winner = 1'b0;
    end else if (req1) begin
      winner = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      bus_valid <= 1'b0;
      bus_data  <= '0;
      rdata     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            sel       <= winner;
            last      <= winner;
            bus_data  <= winner ? din1 : din0;
            gnt0      <= ~winner;
            gnt1      <= winner;
            bus_valid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // sel still names the owner of the in-flight request
          if (bus_resp_valid) begin
            rdata <= bus_rdata;
            done0 <= ~sel;
            done1 <= sel;
            state <= ST_IDLE;
          end
        end
        default: begin
          bus_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: driver pushes model-predicted grants/responses, monitor pops and compares.
module tb_mem_port_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          bus_ready = 1'b0, bus_resp_valid = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          gnt0, gnt1, done0, done1, sel, bus_valid;
  logic [DW-1:0] bus_data, rdata;

  mem_port_arbiter #(.dataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .sel(sel), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_ready(bus_ready), .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          who;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]    pat;
    logic [DW-1:0] d0, d1, rd;
    int            rdy, rsp, mode, gap;
    bit            spur, rst_wait;
  } txn_t;

  int            total = 0, bad = 0;
  int            cyc = 0;
  int            last_gnt_cyc = -100;
  exp_t          gnt_q[$], done_q[$];
  txn_t          txns[$];
  logic          model_last = 1'b1;
  logic [DW-1:0] exp_bus = '0;
  logic          exp_sel = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference arbitration: who should win given the requests seen in IDLE.
  function automatic logic pick(input logic [1:0] pat);
    logic w;
`ifdef ARB_ROUND_ROBIN_EN
    if (pat == 2'b11) w = !model_last;
    else              w = (pat == 2'b10);
`else
    w = (pat == 2'b10);
`endif
    model_last = w;
    return w;
  endfunction

  function automatic txn_t mk(input logic [1:0] pat, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [DW-1:0] rd, input int rdy, input int rsp, input bit spur,
                              input int mode, input int gap, input bit rst_wait);
    txn_t t;
    t.pat = pat; t.d0 = d0; t.d1 = d1; t.rd = rd; t.rdy = rdy; t.rsp = rsp;
    t.spur = spur; t.mode = mode; t.gap = gap; t.rst_wait = rst_wait;
    return t;
  endfunction

  task automatic apply(input txn_t t);
    req0 = t.pat[0];
    req1 = t.pat[1];
    din0 = t.d0;
    din1 = t.d1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pulses"}, {gnt1, gnt0, done1, done0}, 4'b0000);
    chk({tag, "_bus_valid"}, bus_valid, 1'b0);
    chk({tag, "_sel"}, sel, 1'b0);
    chk({tag, "_bus_data"}, bus_data, '0);
    chk({tag, "_rdata"}, rdata, '0);
  endtask

  task automatic build();
    // mode: when the next request pattern appears (0 after done, 1 during ISSUE, 2 during WAIT)
    txns.push_back(mk(2'b10, 32'h0000_0111, 32'h1000_0004, 32'hDEAD_BEEF, 0, 1, 1'b0, 0, 2, 1'b0));
    txns.push_back(mk(2'b11, 32'hA000_0000, 32'hB000_0000, 32'h0000_0A01, 0, 0, 1'b0, 1, 0, 1'b0));
    txns.push_back(mk(2'b11, 32'hA000_0001, 32'hB000_0001, 32'h0000_0A02, 0, 0, 1'b0, 1, 0, 1'b0));
    txns.push_back(mk(2'b11, 32'hA000_0002, 32'hB000_0002, 32'h0000_0A03, 0, 0, 1'b0, 1, 0, 1'b0));
    txns.push_back(mk(2'b11, 32'hA000_0003, 32'hB000_0003, 32'h0000_0A04, 0, 0, 1'b0, 0, 1, 1'b0));
    txns.push_back(mk(2'b01, 32'h0C0F_FEE0, 32'h1111_1111, 32'h5555_AAAA, 5, 2, 1'b1, 0, 0, 1'b0));
    txns.push_back(mk(2'b10, 32'h2222_2222, 32'h3333_3333, 32'h7777_0001, 1, 3, 1'b0, 2, 0, 1'b0));
    txns.push_back(mk(2'b01, 32'h4444_4444, 32'h6666_6666, 32'h7777_0002, 0, 0, 1'b0, 0, 1, 1'b0));
    txns.push_back(mk(2'b10, 32'h8888_8888, 32'h9999_9999, 32'hBAD0_BAD0, 0, 2, 1'b0, 0, 1, 1'b1));
    txns.push_back(mk(2'b11, 32'hC0DE_0000, 32'hC0DE_0001, 32'h1234_5678, 1, 1, 1'b0, 0, 0, 1'b0));
    for (int i = 0; i < 30; i++) begin
      int rdy;
      rdy = $urandom_range(0, 3);
      txns.push_back(mk(2'($urandom_range(1, 3)), $urandom, $urandom, $urandom, rdy,
                        $urandom_range(0, 3), (rdy > 0) && ($urandom_range(0, 1) == 1),
                        $urandom_range(0, 2), $urandom_range(0, 2), 1'b0));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (gnt0 || gnt1) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_gnt", {gnt1, gnt0}, 2'b00);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_who", {gnt1, gnt0}, e.who ? 2'b10 : 2'b01);
          chk("gnt_sel", sel, e.who);
          chk("gnt_bus_data", bus_data, e.data);
          chk("gnt_bus_valid", bus_valid, 1'b1);
          chk("gnt_spacing", (cyc - last_gnt_cyc >= 3), 1'b1);
          last_gnt_cyc = cyc;
          exp_bus = e.data;
          exp_sel = e.who;
        end
      end
      if (done0 || done1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", {done1, done0}, 2'b00);
        end else begin
          e = done_q.pop_front();
          chk("done_who", {done1, done0}, e.who ? 2'b10 : 2'b01);
          chk("done_rdata", rdata, e.data);
          chk("done_sel", sel, e.who);
        end
      end
      if (bus_valid) begin
        chk("bus_data_hold", bus_data, exp_bus);
        chk("bus_sel_hold", sel, exp_sel);
      end
    end
  end

  initial begin : driver
    txn_t t, nxt, idle_t;
    exp_t e;
    int   n;
    idle_t = mk(2'b00, '0, '0, '0, 0, 0, 1'b0, 0, 0, 1'b0);
    build();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    apply(txns[0]);
    for (int i = 0; i < txns.size(); i++) begin
      t = txns[i];
      if (i + 1 < txns.size()) nxt = txns[i+1];
      else                     nxt = idle_t;
      e.who  = pick(t.pat);
      e.data = e.who ? t.d1 : t.d0;
      gnt_q.push_back(e);
      e.data = t.rd;
      done_q.push_back(e);

      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(gnt0 || gnt1) && n < 8);
      chk("gnt_latency", n, 1);
      if (t.mode == 1) apply(nxt);
      else begin
        req0 = 1'b0;
        req1 = 1'b0;
      end

      for (int k = 0; k < t.rdy; k++) begin
        bus_ready      = 1'b0;
        bus_resp_valid = t.spur && (k == 0);
        bus_rdata      = $urandom;
        @(negedge clk);
        chk("issue_valid", bus_valid, 1'b1);
        chk("issue_no_done", done0 | done1, 1'b0);
      end
      bus_resp_valid = 1'b0;
      bus_ready      = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      chk("valid_drop", bus_valid, 1'b0);
      if (t.mode == 2) apply(nxt);

      if (t.rst_wait) begin
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("async_reset");
        done_q.delete();
        model_last     = 1'b1;
        last_gnt_cyc   = -100;
        exp_bus        = '0;
        exp_sel        = 1'b0;
        req0           = 1'b0;
        req1           = 1'b0;
        bus_resp_valid = 1'b1;
        bus_rdata      = $urandom;
        @(negedge clk);
        chk("reset_no_done", done0 | done1, 1'b0);
        check_reset("reset_hold");
        bus_resp_valid = 1'b0;
        rst_n          = 1'b1;
      end else begin
        for (int k = 0; k < t.rsp; k++) begin
          bus_rdata = $urandom;
          @(negedge clk);
          chk("wait_no_done", done0 | done1, 1'b0);
        end
        bus_resp_valid = 1'b1;
        bus_rdata      = t.rd;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        bus_rdata      = $urandom;
        chk("done_latency", done0 | done1, 1'b1);
      end

      if (t.mode == 0 || t.rst_wait) begin
        repeat (t.gap) @(negedge clk);
        apply(nxt);
      end
    end
    repeat (4) @(negedge clk);
    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
